// File: rtl/disp_pkg.sv
// Shared constants and leading-zero helper for the multiplexed 7-segment scanner.
package disp_pkg;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   localparam int DEF_DIGITS   = 4;
   localparam int DEF_PRESCALE = 50000;
   localparam int DEF_DEADTIME = 4;
   localparam int MAX_DIGITS   = 16;

   // Bit k set when digits k..digits-1 are all zero; digit 0 is never flagged.
   function automatic logic [MAX_DIGITS-1:0] lz_mask(
      input logic [4*MAX_DIGITS-1:0] value,
      input int                      digits
   );
      logic [MAX_DIGITS-1:0] m;
      logic                  z;
      m = '0;
      z = 1'b1;
      for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
         if (k < digits) begin
            z    = z & (value[4*k +: 4] == 4'h0);
            m[k] = z;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/display_scan_mux_scan_timer.sv
// Slot prescaler and digit index for the display scanner.
module scan_timer #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic [$clog2(PRESCALE)-1:0] cnt,
   output logic [$clog2(DIGITS)-1:0]   idx,
   output logic                        slot_end,
   output logic                        frame_end
);

   localparam int CW = $clog2(PRESCALE);
   localparam int IW = $clog2(DIGITS);

   assign slot_end  = (cnt == CW'(PRESCALE - 1));
   assign frame_end = slot_end && (idx == IW'(DIGITS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/display_scan_mux.sv
// Double-buffered multi-digit scanner with leading-zero blanking and anode dead-time.
module display_scan_mux
   import disp_pkg::*;
#(
   parameter int DIGITS   = DEF_DIGITS,
   parameter int PRESCALE = DEF_PRESCALE,
   parameter int DEADTIME = DEF_DEADTIME
) (
   input  logic [0:0]          clk,
   input  logic [0:0]          rst,
   input  logic [4*DIGITS-1:0] value_in,
   input  logic [0:0]          load,
   input  logic [0:0]          blank_lz,
   output logic [3:0]          digit_code,
   output logic [DIGITS-1:0]   an_n,
   output logic [0:0]          frame_tick,
   output logic [0:0]          load_pending
);

   localparam int CW = $clog2(PRESCALE);
   localparam int IW = $clog2(DIGITS);

   logic [CW-1:0]            cnt;
   logic [IW-1:0]            idx;
   logic                     slot_end;
   logic                     frame_end;

   logic [DIGITS-1:0][3:0]   disp;
   logic [DIGITS-1:0][3:0]   pend;
   logic [MAX_DIGITS-1:0]    lz_all;
   logic [DIGITS-1:0]        lz;
   logic [DIGITS-1:0]        an_next;
   logic [3:0]               code_next;

   scan_timer #(
      .DIGITS   (DIGITS),
      .PRESCALE (PRESCALE)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .cnt       (cnt),
      .idx       (idx),
      .slot_end  (slot_end),
      .frame_end (frame_end)
   );

   // Commit only at the frame boundary so a frame never mixes old and new digits.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp         <= '0;
         pend         <= '0;
         load_pending <= 1'b0;
      end else if (frame_end) begin
         load_pending <= 1'b0;
         if (load) begin
            disp <= value_in;
         end else if (load_pending) begin
            disp <= pend;
         end
      end else if (load) begin
         pend         <= value_in;
         load_pending <= 1'b1;
      end
   end

   always_comb begin
      lz_all    = lz_mask((4*MAX_DIGITS)'(disp), DIGITS);
      lz        = lz_all[DIGITS-1:0];
      an_next   = '1;
      code_next = disp[idx];
      if (cnt >= CW'(DEADTIME)) begin
         an_next[idx] = 1'b0;
      end
      if (blank_lz && lz[idx]) begin
         code_next = BLANK_CODE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         an_n       <= '1;
         digit_code <= BLANK_CODE;
         frame_tick <= 1'b0;
      end else begin
         an_n       <= an_next;
         digit_code <= code_next;
         frame_tick <= frame_end;
      end
   end

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench: per-cycle scoreboard plus per-frame table checks.
module tb_display_scan_mux;

   localparam int D  = 4;
   localparam int P  = 8;
   localparam int DT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic        blank_lz;
   logic [15:0] value_in;
   logic [3:0]  digit_code;
   logic [3:0]  an_n;
   logic        frame_tick;
   logic        load_pending;

   display_scan_mux #(
      .DIGITS   (D),
      .PRESCALE (P),
      .DEADTIME (DT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .value_in     (value_in),
      .load         (load),
      .blank_lz     (blank_lz),
      .digit_code   (digit_code),
      .an_n         (an_n),
      .frame_tick   (frame_tick),
      .load_pending (load_pending)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] code;
      logic [3:0] an;
      logic       tick;
      logic       lp;
   } exp_t;

   typedef struct {
      logic [15:0] v;
      logic        bz;
      logic [15:0] codes;
   } vec_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int          t;
   logic [15:0] mdisp;
   logic [15:0] mpend;
   logic        mlp;
   int          cyc = 0;
   logic        cur_tick = 1'b0;
   logic [3:0]  obs_code[4];
   int          obs_on[4];
   int          lp_hi;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)",
                  nm, act, req, cyc);
      end
   endtask

   // Reference: slot position and digit follow from cycles since reset release.
   task automatic model(input logic r, input logic ld,
                        input logic [15:0] v, input logic bz,
                        output exp_t e);
      int         c;
      int         i;
      logic       fe;
      logic [3:0] dg;
      if (r) begin
         e     = '{code: 4'hF, an: 4'hF, tick: 1'b0, lp: 1'b0};
         t     = 0;
         mdisp = '0;
         mpend = '0;
         mlp   = 1'b0;
      end else begin
         c  = t % P;
         i  = (t / P) % D;
         fe = (c == P - 1) && (i == D - 1);
         dg = mdisp[4*i +: 4];
         if (bz && i >= 1 && (mdisp >> (4*i)) == 16'h0)
            e.code = 4'hF;
         else
            e.code = dg;
         e.an   = (c >= DT) ? ~(4'b0001 << i) : 4'hF;
         e.tick = fe;
         if (fe) begin
            if (ld) mdisp = v;
            else if (mlp) mdisp = mpend;
            mlp = 1'b0;
         end else if (ld) begin
            mpend = v;
            mlp   = 1'b1;
         end
         e.lp = mlp;
         t++;
      end
   endtask

   task automatic clear_obs();
      for (int k = 0; k < 4; k++) begin
         obs_code[k] = 4'bx;
         obs_on[k]   = 0;
      end
      lp_hi = 0;
   endtask

   task automatic step(input logic r, input logic ld,
                       input logic [15:0] v, input logic bz);
      exp_t e;
      exp_t g;
      rst      = r;
      load     = ld;
      value_in = v;
      blank_lz = bz;
      model(r, ld, v, bz, e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      g = sb.pop_front();
      chk("digit_code", {28'h0, digit_code}, {28'h0, g.code});
      chk("an_n", {28'h0, an_n}, {28'h0, g.an});
      chk("frame_tick", {31'h0, frame_tick}, {31'h0, g.tick});
      chk("load_pending", {31'h0, load_pending}, {31'h0, g.lp});
      cur_tick = frame_tick;
      for (int k = 0; k < 4; k++) begin
         if (an_n[k] == 1'b0) begin
            obs_code[k] = digit_code;
            obs_on[k]++;
         end
      end
      if (load_pending) lp_hi++;
   endtask

   task automatic idle(input int n, input logic bz);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, bz);
   endtask

   task automatic run_until_tick(input logic bz);
      int n;
      n = 0;
      do begin
         step(1'b0, 1'b0, 16'h0, bz);
         n++;
      end while (!cur_tick && n < 40);
      chk("tick_timeout", {31'h0, cur_tick}, 32'h1);
   endtask

   task automatic run_frame(input logic bz, output int period);
      int c0;
      if (!cur_tick) run_until_tick(bz);
      c0 = cyc;
      clear_obs();
      run_until_tick(bz);
      period = cyc - c0;
   endtask

   task automatic check_frame(input string nm, input logic [15:0] codes);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s code%0d", nm, k),
             {28'h0, obs_code[k]}, {28'h0, codes[4*k +: 4]});
         chk($sformatf("%s on%0d", nm, k), obs_on[k], P - DT);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[6];
      int   per;

      tbl[0] = '{v: 16'h1234, bz: 1'b0, codes: 16'h1234};
      tbl[1] = '{v: 16'h0070, bz: 1'b1, codes: 16'hFF70};
      tbl[2] = '{v: 16'h0000, bz: 1'b1, codes: 16'hFFF0};
      tbl[3] = '{v: 16'h0000, bz: 1'b0, codes: 16'h0000};
      tbl[4] = '{v: 16'h0105, bz: 1'b1, codes: 16'hF105};
      tbl[5] = '{v: 16'hE0A0, bz: 1'b1, codes: 16'hE0A0};

      rst      = 1'b1;
      load     = 1'b0;
      blank_lz = 1'b0;
      value_in = '0;
      clear_obs();

      // Reset held three cycles, then release.
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 16'h0, 1'b0);
         chk("rst an_n", {28'h0, an_n}, 32'hF);
         chk("rst digit_code", {28'h0, digit_code}, 32'hF);
      end
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk("c1 digit_code", {28'h0, digit_code}, 32'h0);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk("c2 an_n", {28'h0, an_n}, 32'hF);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk("c3 an_n", {28'h0, an_n}, 32'hE);
      chk("c3 digit_code", {28'h0, digit_code}, 32'h0);

      // Table: load a value, then check the frame after commit.
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, tbl[i].v, tbl[i].bz);
         run_frame(tbl[i].bz, per);
         check_frame($sformatf("tbl%0d", i), tbl[i].codes);
         chk($sformatf("tbl%0d period", i), per, D * P);
         chk($sformatf("tbl%0d lp", i), lp_hi, 0);
      end

      // Double buffer: two loads mid-frame, newest wins at next frame.
      step(1'b0, 1'b1, 16'h1234, 1'b0);
      run_frame(1'b0, per);
      clear_obs();
      idle(12, 1'b0);
      step(1'b0, 1'b1, 16'h5678, 1'b0);
      idle(4, 1'b0);
      step(1'b0, 1'b1, 16'h9ABC, 1'b0);
      run_until_tick(1'b0);
      check_frame("dbuf old", 16'h1234);
      chk("dbuf lp cycles", lp_hi, 19);
      run_frame(1'b0, per);
      check_frame("dbuf new", 16'h9ABC);

      // Load coincident with frame_end commits directly.
      clear_obs();
      idle(31, 1'b0);
      step(1'b0, 1'b1, 16'h4321, 1'b0);
      chk("coin tick", {31'h0, cur_tick}, 32'h1);
      chk("coin lp", lp_hi, 0);
      run_frame(1'b0, per);
      check_frame("coin", 16'h4321);
      chk("coin lp next", lp_hi, 0);

      // Reset mid-frame with a pending load.
      step(1'b0, 1'b1, 16'h7777, 1'b0);
      idle(19, 1'b0);
      chk("pre-rst lp", {31'h0, load_pending}, 32'h1);
      step(1'b1, 1'b0, 16'h0, 1'b0);
      step(1'b1, 1'b0, 16'h0, 1'b0);
      chk("mid-rst an_n", {28'h0, an_n}, 32'hF);
      chk("mid-rst digit_code", {28'h0, digit_code}, 32'hF);
      chk("mid-rst lp", {31'h0, load_pending}, 32'h0);
      chk("mid-rst tick", {31'h0, frame_tick}, 32'h0);
      run_frame(1'b0, per);
      check_frame("post-rst f1", 16'h0000);
      run_frame(1'b0, per);
      check_frame("post-rst f2", 16'h0000);
      chk("post-rst period", per, D * P);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
